// File: rtl/updown_cnt_scan.sv
// Reversible 4-digit hex/BCD counter with prescaled tick and a registered
// digit-scan multiplexer for a common-anode display (active-low anodes).
module updown_cnt_scan #(
   parameter int CNT_DIV  = 100000000,
   parameter int SCAN_DIV = 100000,
   parameter bit BCD      = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        up,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [15:0] cnt,
   output logic [3:0]  di,
   output logic [3:0]  an
);

   localparam int PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(CNT_DIV - 1);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

   logic [PW-1:0] r_pre;
   logic [SW-1:0] r_scan;
   logic [1:0]    r_idx;
   logic [15:0]   r_cnt;
   logic [3:0]    r_di;
   logic [3:0]    r_an;
   logic          w_tick;

   // Saturate each nibble to 9 so a BCD counter never holds a non-decimal digit.
   function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int k = 0; k < 4; k++)
         if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
      return r;
   endfunction

   function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic inc);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (c) begin
            if (inc) begin
               if (v[4*k +: 4] == 4'd9) r[4*k +: 4] = 4'd0;
               else begin
                  r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (v[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'd9;
               else begin
                  r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   assign w_tick = en && (r_pre == PRE_MAX);

   // Prescaler and count register; load restarts the tick phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre <= '0;
         r_cnt <= '0;
      end else if (load) begin
         r_pre <= '0;
         r_cnt <= BCD ? bcd_clamp(load_val) : load_val;
      end else if (en) begin
         r_pre <= w_tick ? '0 : r_pre + PW'(1);
         if (w_tick) begin
            if (BCD) r_cnt <= bcd_step(r_cnt, up);
            else     r_cnt <= up ? r_cnt + 16'd1 : r_cnt - 16'd1;
         end
      end
   end

   // Scan timing is free-running; anode and nibble share one edge so they never mismatch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan <= '0;
         r_idx  <= 2'd0;
         r_an   <= 4'b1110;
         r_di   <= 4'd0;
      end else begin
         if (r_scan == SCAN_MAX) begin
            r_scan <= '0;
            r_idx  <= r_idx + 2'd1;
         end else begin
            r_scan <= r_scan + SW'(1);
         end
         r_an <= ~(4'b0001 << r_idx);
         r_di <= r_cnt[{r_idx, 2'b00} +: 4];
      end
   end

   assign cnt = r_cnt;
   assign di  = r_di;
   assign an  = r_an;

endmodule

// File: tb/tb_updown_cnt_scan.sv
// Bench for updown_cnt_scan: hex and BCD instances on shared inputs, checked
// against an integer reference model plus directed constant expectations.
module tb_updown_cnt_scan;

   localparam int CD = 4;
   localparam int SD = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        up = 1'b1;
   logic        load = 1'b0;
   logic [15:0] load_val = 16'h0;
   logic [15:0] cnt_h, cnt_b;
   logic [3:0]  di_h, di_b, an_h, an_b;

   int checks = 0;
   int failures = 0;

   int m_pre, m_scan, m_idx, m_hex, m_dec;
   logic [3:0] m_an, m_di_h, m_di_b;

   updown_cnt_scan #(.CNT_DIV(CD), .SCAN_DIV(SD), .BCD(1'b0)) u_hex (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .cnt(cnt_h), .di(di_h), .an(an_h));

   updown_cnt_scan #(.CNT_DIV(CD), .SCAN_DIV(SD), .BCD(1'b1)) u_bcd (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .cnt(cnt_b), .di(di_b), .an(an_b));

   always #5 clk = ~clk;

   function automatic logic [15:0] bcd_of(input int d);
      return 16'(((d / 1000) % 10) * 4096 + ((d / 100) % 10) * 256 + ((d / 10) % 10) * 16 + d % 10);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int n, w;
      logic tick;
      if (rst) begin
         m_pre = 0; m_scan = 0; m_idx = 0; m_hex = 0; m_dec = 0;
         m_an = 4'b1110; m_di_h = 4'd0; m_di_b = 4'd0;
      end else begin
         m_an   = ~(4'b0001 << m_idx);
         m_di_h = 4'((m_hex >> (4 * m_idx)) & 15);
         m_di_b = 4'((bcd_of(m_dec) >> (4 * m_idx)) & 15);
         tick = en && (m_pre == CD - 1);
         if (load) begin
            m_hex = int'(load_val);
            m_dec = 0; w = 1;
            for (int k = 0; k < 4; k++) begin
               n = (int'(load_val) >> (4 * k)) & 15;
               if (n > 9) n = 9;
               m_dec += n * w;
               w *= 10;
            end
            m_pre = 0;
         end else if (en) begin
            if (tick) begin
               m_pre = 0;
               m_hex = up ? (m_hex + 1) % 65536 : (m_hex + 65535) % 65536;
               m_dec = up ? (m_dec + 1) % 10000 : (m_dec + 9999) % 10000;
            end else begin
               m_pre++;
            end
         end
         if (m_scan == SD - 1) begin
            m_scan = 0;
            m_idx = (m_idx + 1) % 4;
         end else begin
            m_scan++;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("cnt_hex", cnt_h, 16'(m_hex));
      chk("cnt_bcd", cnt_b, bcd_of(m_dec));
      chk("an_hex", {12'h0, an_h}, {12'h0, m_an});
      chk("an_bcd", {12'h0, an_b}, {12'h0, m_an});
      chk("di_hex", {12'h0, di_h}, {12'h0, m_di_h});
      chk("di_bcd", {12'h0, di_b}, {12'h0, m_di_b});
      chk("an_onehot", 16'($countones(~an_h)), 16'd1);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      // Reset, then hold reset under count/load activity.
      steps(3);
      chk("rst_cnt", cnt_h, 16'h0000);
      chk("rst_an", {12'h0, an_h}, 16'h000E);
      chk("rst_di", {12'h0, di_h}, 16'h0000);
      en = 1'b1; load = 1'b1; load_val = 16'h1234;
      steps(3);
      chk("rst_hold_cnt", cnt_h, 16'h0000);
      chk("rst_hold_an", {12'h0, an_b}, 16'h000E);
      rst = 1'b0;

      // Hex up-count across the wrap.
      load_val = 16'hFFFE; up = 1'b1;
      step();
      load = 1'b0;
      steps(3);
      chk("hex_pre_tick", cnt_h, 16'hFFFE);
      step();
      chk("hex_ffff", cnt_h, 16'hFFFF);
      steps(4);
      chk("hex_wrap", cnt_h, 16'h0000);

      // BCD down-count across the wrap, then clamped load.
      load = 1'b1; load_val = 16'h0001; up = 1'b0;
      step();
      load = 1'b0;
      steps(4);
      chk("bcd_0000", cnt_b, 16'h0000);
      steps(4);
      chk("bcd_9999", cnt_b, 16'h9999);
      steps(4);
      chk("bcd_9998", cnt_b, 16'h9998);
      load = 1'b1; load_val = 16'hA5F3;
      step();
      load = 1'b0; en = 1'b0;
      chk("bcd_clamp", cnt_b, 16'h9593);
      chk("hex_load", cnt_h, 16'hA5F3);

      // Enable freeze and direction flip mid-prescale.
      load = 1'b1; load_val = 16'h0000; up = 1'b1; en = 1'b1;
      step();
      load = 1'b0;
      steps(12);
      chk("en_0003", cnt_h, 16'h0003);
      steps(2);
      en = 1'b0;
      steps(10);
      chk("en_frozen", cnt_h, 16'h0003);
      en = 1'b1; up = 1'b0;
      step();
      chk("phase_kept", cnt_h, 16'h0003);
      step();
      chk("dir_flip", cnt_h, 16'h0002);

      // Load colliding with a tick.
      up = 1'b1;
      steps(3);
      load = 1'b1; load_val = 16'h1234;
      step();
      load = 1'b0;
      chk("collide_load", cnt_h, 16'h1234);
      steps(3);
      chk("collide_hold", cnt_h, 16'h1234);
      step();
      chk("collide_next", cnt_h, 16'h1235);

      // Scan sequence on a static value.
      load = 1'b1; load_val = 16'h4321; en = 1'b0;
      step();
      load = 1'b0;
      steps(16);

      // Randomized activity against the model.
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 49) == 0);
         load     = ($urandom_range(0, 15) == 0);
         en       = ($urandom_range(0, 3) != 0);
         up       = 1'($urandom_range(0, 1));
         load_val = 16'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
